// File: rtl/modport_systolic_array.sv
// Weight-stationary N x N matrix engine: queued input/partial rows in, one result row per cycle out.
// Build option SA_SATURATE_EN: clamp results to the signed DW range instead of wrapping.
module modport_systolic_array #(
  parameter int N         = 32,
  parameter int DW        = 16,
  parameter int FIFO_ROWS = 2*N
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 weight_en,
  input  logic                 input_en,
  input  logic                 partial_en,
  input  logic [$clog2(N)-1:0] row_in_en,
  input  logic [$clog2(N)-1:0] row_ps_en,
  input  logic [DW*N-1:0]      array_in,
  input  logic [DW*N-1:0]      array_in_partials,
  output logic                 out_en,
  output logic [$clog2(N)-1:0] row_out,
  output logic [DW*N-1:0]      array_output,
  output logic                 drained,
  output logic                 fifo_has_space
);

  localparam int IW  = $clog2(N);
  localparam int RW  = DW*N;
  localparam int EW  = IW+RW;
  localparam int PRW = 2*DW;
  localparam int AW  = 2*DW+IW;
  localparam int PW  = (FIFO_ROWS > 1) ? $clog2(FIFO_ROWS) : 1;
  localparam int CW  = $clog2(FIFO_ROWS+1);
  localparam int D   = N+1;

  localparam logic [CW-1:0] FULL = CW'(FIFO_ROWS);
  localparam logic [CW-1:0] NEED = CW'(N);

`ifdef SA_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_HI =
    {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO =
    {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
`endif

  // ---------------- weights ----------------
  logic [RW-1:0] w_q [N];
  logic [RW-1:0] w_d [N];

  // overwrite the addressed weight row, keep the rest
  always_comb begin
    for (int r = 0; r < N; r++) begin
      w_d[r] = w_q[r];
    end
    if (weight_en) begin
      w_d[row_in_en] = array_in;
    end
  end

  // weight register bank
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int r = 0; r < N; r++) begin
        w_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < N; r++) begin
        w_q[r] <= w_d[r];
      end
    end
  end

  // ---------------- row FIFOs ----------------
  logic [EW-1:0] in_mem_q [FIFO_ROWS];
  logic [EW-1:0] ps_mem_q [FIFO_ROWS];

  logic [PW-1:0] in_wp_q, in_wp_d;
  logic [PW-1:0] in_rp_q, in_rp_d;
  logic [PW-1:0] ps_wp_q, ps_wp_d;
  logic [PW-1:0] ps_rp_q, ps_rp_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d;
  logic [CW-1:0] ps_cnt_q, ps_cnt_d;

  logic issue;
  logic in_push;
  logic ps_push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_ROWS-1)) ? '0 : p + 1'b1;
  endfunction

  // pairing, push acceptance and pointer/count update
  always_comb begin
    issue    = (in_cnt_q != '0) && (ps_cnt_q != '0);
    in_push  = input_en && !weight_en &&
               ((in_cnt_q != FULL) || issue);
    ps_push  = partial_en && ((ps_cnt_q != FULL) || issue);
    in_wp_d  = in_push ? ptr_inc(in_wp_q) : in_wp_q;
    ps_wp_d  = ps_push ? ptr_inc(ps_wp_q) : ps_wp_q;
    in_rp_d  = issue ? ptr_inc(in_rp_q) : in_rp_q;
    ps_rp_d  = issue ? ptr_inc(ps_rp_q) : ps_rp_q;
    in_cnt_d = in_cnt_q + CW'(in_push) - CW'(issue);
    ps_cnt_d = ps_cnt_q + CW'(ps_push) - CW'(issue);
  end

  // FIFO storage; contents are qualified by the counts, so no reset
  always_ff @(posedge clk) begin
    if (in_push) begin
      in_mem_q[in_wp_q] <= {row_in_en, array_in};
    end
    if (ps_push) begin
      ps_mem_q[ps_wp_q] <= {row_ps_en, array_in_partials};
    end
  end

  logic [EW-1:0] in_head;
  logic [EW-1:0] ps_head;
  logic [IW-1:0] ps_tag_unused;

  assign in_head       = in_mem_q[in_rp_q];
  assign ps_head       = ps_mem_q[ps_rp_q];
  assign ps_tag_unused = ps_head[EW-1 -: IW];

  // ---------------- row compute ----------------
  logic [RW-1:0]          res_row;
  logic signed [AW-1:0]   acc;
  logic signed [PRW-1:0]  prod;

  // one full output row from the FIFO heads and current weights
  always_comb begin
    res_row = '0;
    acc     = '0;
    prod    = '0;
    for (int j = 0; j < N; j++) begin
      acc = AW'($signed(ps_head[DW*j +: DW]));
      for (int k = 0; k < N; k++) begin
        prod = PRW'($signed(in_head[DW*k +: DW])) *
               PRW'($signed(w_q[k][DW*j +: DW]));
        acc  = acc + AW'(prod);
      end
`ifdef SA_SATURATE_EN
      if (acc > SAT_HI) begin
        res_row[DW*j +: DW] = SAT_HI[DW-1:0];
      end else if (acc < SAT_LO) begin
        res_row[DW*j +: DW] = SAT_LO[DW-1:0];
      end else begin
        res_row[DW*j +: DW] = acc[DW-1:0];
      end
`else
      res_row[DW*j +: DW] = acc[DW-1:0];
`endif
    end
  end

  // ---------------- delay line ----------------
  logic [D-1:0]  v_q, v_d;
  logic [IW-1:0] tag_q [D];
  logic [IW-1:0] tag_d [D];
  logic [RW-1:0] dat_q [D];
  logic [RW-1:0] dat_d [D];

  // shift a stage only when its source is valid, so the last stage holds
  always_comb begin
    v_d[0]   = issue;
    tag_d[0] = issue ? in_head[EW-1 -: IW] : tag_q[0];
    dat_d[0] = issue ? res_row : dat_q[0];
    for (int k = 1; k < D; k++) begin
      v_d[k]   = v_q[k-1];
      tag_d[k] = v_q[k-1] ? tag_q[k-1] : tag_q[k];
      dat_d[k] = v_q[k-1] ? dat_q[k-1] : dat_q[k];
    end
  end

  // delay-line registers
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      v_q <= '0;
      for (int k = 0; k < D; k++) begin
        tag_q[k] <= '0;
        dat_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < D; k++) begin
        tag_q[k] <= tag_d[k];
        dat_q[k] <= dat_d[k];
      end
    end
  end

  // ---------------- status ----------------
  logic drained_q, drained_d;

  // drain status lags the state it summarises by one cycle
  always_comb begin
    drained_d = (in_cnt_q == '0) && (ps_cnt_q == '0) && (v_q == '0);
  end

  // FIFO pointers, counts and drain flag
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      in_wp_q   <= '0;
      in_rp_q   <= '0;
      ps_wp_q   <= '0;
      ps_rp_q   <= '0;
      in_cnt_q  <= '0;
      ps_cnt_q  <= '0;
      drained_q <= 1'b1;
    end else begin
      in_wp_q   <= in_wp_d;
      in_rp_q   <= in_rp_d;
      ps_wp_q   <= ps_wp_d;
      ps_rp_q   <= ps_rp_d;
      in_cnt_q  <= in_cnt_d;
      ps_cnt_q  <= ps_cnt_d;
      drained_q <= drained_d;
    end
  end

  assign out_en         = v_q[D-1];
  assign row_out        = tag_q[D-1];
  assign array_output   = dat_q[D-1];
  assign drained        = drained_q;
  assign fifo_has_space = ((FULL - in_cnt_q) >= NEED) &&
                          ((FULL - ps_cnt_q) >= NEED);

endmodule

// File: tb/tb_modport_systolic_array.sv
// Bench for modport_systolic_array: random and directed rows against a
// queue-based behavioural model of the matrix engine.
module tb_modport_systolic_array;

  localparam int N  = 32;
  localparam int DW = 16;
  localparam int FR = 2*N;
  localparam int IW = 5;
  localparam int RW = DW*N;

  logic          clk;
  logic          nRST;
  logic          weight_en;
  logic          input_en;
  logic          partial_en;
  logic [IW-1:0] row_in_en;
  logic [IW-1:0] row_ps_en;
  logic [RW-1:0] array_in;
  logic [RW-1:0] array_in_partials;
  logic          out_en;
  logic [IW-1:0] row_out;
  logic [RW-1:0] array_output;
  logic          drained;
  logic          fifo_has_space;

  modport_systolic_array #(
    .N(N), .DW(DW), .FIFO_ROWS(FR)
  ) dut (
    .clk(clk),
    .nRST(nRST),
    .weight_en(weight_en),
    .input_en(input_en),
    .partial_en(partial_en),
    .row_in_en(row_in_en),
    .row_ps_en(row_ps_en),
    .array_in(array_in),
    .array_in_partials(array_in_partials),
    .out_en(out_en),
    .row_out(row_out),
    .array_output(array_output),
    .drained(drained),
    .fifo_has_space(fifo_has_space)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] tag;
    logic [RW-1:0] d;
  } row_t;

  typedef struct {
    int            due;
    logic [IW-1:0] tag;
    logic [RW-1:0] d;
  } exp_t;

  row_t                 qin[$];
  row_t                 qps[$];
  exp_t                 expq[$];
  logic signed [DW-1:0] mw [N][N];
  logic [RW-1:0]        last_out;
  bit                   out_now;
  int                   cyc;
  int                   checks;
  int                   failures;

  task automatic chk(input string tag, input logic [RW-1:0] got,
                     input logic [RW-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [RW-1:0] fill(input logic [DW-1:0] v);
    logic [RW-1:0] r;
    for (int j = 0; j < N; j++) r[DW*j +: DW] = v;
    return r;
  endfunction

  function automatic logic [RW-1:0] rnd_row();
    logic [RW-1:0] r;
    for (int j = 0; j < N; j++) r[DW*j +: DW] = DW'($urandom);
    return r;
  endfunction

  function automatic logic [RW-1:0] ident(input int r);
    logic [RW-1:0] w;
    w = '0;
    w[DW*r +: DW] = 16'd1;
    return w;
  endfunction

  // out[j] = P[j] + sum_k X[k]*W[k][j], then wrap or clamp to DW bits
  function automatic logic [RW-1:0] model_row(input logic [RW-1:0] x,
                                              input logic [RW-1:0] p);
    logic [RW-1:0] r;
    longint        acc;
    for (int j = 0; j < N; j++) begin
      acc = longint'($signed(p[DW*j +: DW]));
      for (int k = 0; k < N; k++)
        acc += longint'($signed(x[DW*k +: DW])) * longint'(mw[k][j]);
`ifdef SA_SATURATE_EN
      if (acc > 32767) acc = 32767;
      else if (acc < -32768) acc = -32768;
`endif
      r[DW*j +: DW] = acc[DW-1:0];
    end
    return r;
  endfunction

  task automatic step(input bit we, input bit ie, input bit pe,
                      input logic [IW-1:0] rin, input logic [IW-1:0] rps,
                      input logic [RW-1:0] ain, input logic [RW-1:0] aps);
    row_t hx, hp, nr;
    exp_t e;
    bit   drn;
    bit   sp;
    weight_en         = we;
    input_en          = ie;
    partial_en        = pe;
    row_in_en         = rin;
    row_ps_en         = rps;
    array_in          = ain;
    array_in_partials = aps;
    @(posedge clk);
    cyc++;
    drn = (qin.size() == 0) && (qps.size() == 0) &&
          (expq.size() == 0) && !out_now;
    if (qin.size() > 0 && qps.size() > 0) begin
      hx    = qin.pop_front();
      hp    = qps.pop_front();
      e.due = cyc + N;
      e.tag = hx.tag;
      e.d   = model_row(hx.d, hp.d);
      expq.push_back(e);
    end
    if (ie && !we && qin.size() < FR) begin
      nr.tag = rin;
      nr.d   = ain;
      qin.push_back(nr);
    end
    if (pe && qps.size() < FR) begin
      nr.tag = rps;
      nr.d   = aps;
      qps.push_back(nr);
    end
    if (we)
      for (int j = 0; j < N; j++) mw[rin][j] = $signed(ain[DW*j +: DW]);
    #1;
    out_now = 1'b0;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      chk("out_en", RW'(out_en), RW'(1'b1));
      chk("row_out", RW'(row_out), RW'(e.tag));
      chk("array_output", array_output, e.d);
      last_out = e.d;
      out_now  = 1'b1;
    end else begin
      chk("out_en_idle", RW'(out_en), RW'(1'b0));
      chk("output_hold", array_output, last_out);
    end
    sp = ((FR - qin.size()) >= N) && ((FR - qps.size()) >= N);
    chk("drained", RW'(drained), RW'(drn));
    chk("fifo_has_space", RW'(fifo_has_space), RW'(sp));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    weight_en  = 1'b0;
    input_en   = 1'b0;
    partial_en = 1'b0;
    nRST       = 1'b0;
    #1;
    chk("rst_out_en", RW'(out_en), RW'(1'b0));
    chk("rst_array_output", array_output, '0);
    chk("rst_drained", RW'(drained), RW'(1'b1));
    chk("rst_fifo_has_space", RW'(fifo_has_space), RW'(1'b1));
    qin.delete();
    qps.delete();
    expq.delete();
    out_now  = 1'b0;
    last_out = '0;
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) mw[k][j] = '0;
    #2;
    nRST = 1'b1;
  endtask

  logic [DW-1:0] big_want;

  initial begin
    checks            = 0;
    failures          = 0;
    cyc               = 0;
    out_now           = 1'b0;
    last_out          = '0;
    nRST              = 1'b1;
    weight_en         = 1'b0;
    input_en          = 1'b0;
    partial_en        = 1'b0;
    row_in_en         = '0;
    row_ps_en         = '0;
    array_in          = '0;
    array_in_partials = '0;
`ifdef SA_SATURATE_EN
    big_want = 16'h7FFF;
`else
    big_want = 16'hFFE0;
`endif
    #1;
    do_reset();

    // identity weights, input row r = r+1, zero partials
    for (int r = 0; r < N; r++) step(1, 0, 0, IW'(r), '0, ident(r), '0);
    for (int r = 0; r < N; r++)
      step(0, 1, 1, IW'(r), IW'(r), fill(DW'(r+1)), '0);
    idle(N+8);
    chk("ident_last_elem", RW'(array_output[DW-1:0]), RW'(16'd32));
    chk("ident_last_row", RW'(row_out), RW'(5'd31));

    // weights 2, inputs 1, partials 5 -> 69
    for (int r = 0; r < N; r++) step(1, 0, 0, IW'(r), '0, fill(16'd2), '0);
    for (int r = 0; r < N; r++)
      step(0, 1, 1, IW'(r), IW'(r), fill(16'd1), fill(16'd5));
    idle(N+8);
    chk("gemm_69", RW'(array_output[DW-1:0]), RW'(16'd69));

    // large values: wrap or clamp
    for (int r = 0; r < N; r++) step(1, 0, 0, IW'(r), '0, fill(16'd1), '0);
    step(0, 1, 1, 5'd9, 5'd0, fill(16'h7FFF), '0);
    idle(N+4);
    chk("big_elem", RW'(array_output[DW-1:0]), RW'(big_want));

    // fill the input FIFO with no partials; 65th push dropped
    for (int i = 0; i < FR+1; i++) begin
      step(0, 1, 0, IW'(i), '0, rnd_row(), '0);
      if (i == N-1) chk("space_after_32", RW'(fifo_has_space), RW'(1'b1));
      if (i == N)   chk("space_after_33", RW'(fifo_has_space), RW'(1'b0));
    end
    idle(3);
    chk("not_drained_full", RW'(drained), RW'(1'b0));
    for (int i = 0; i < FR; i++) step(0, 0, 1, '0, IW'(i), '0, rnd_row());
    idle(N+8);
    chk("drained_after_stream", RW'(drained), RW'(1'b1));

    // weight_en wins over input_en
    step(1, 1, 0, 5'd3, '0, fill(16'd7), '0);
    idle(3);
    chk("both_en_no_push", RW'(drained), RW'(1'b1));
    step(0, 0, 1, '0, 5'd1, '0, rnd_row());
    idle(3);
    // issue, then rewrite all weights while the row is in flight
    step(0, 1, 0, 5'd5, '0, rnd_row(), '0);
    for (int r = 0; r < N; r++) step(1, 0, 0, IW'(r), '0, rnd_row(), '0);
    idle(N+4);

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 2) != 0, IW'($urandom), IW'($urandom),
           rnd_row(), rnd_row());
    idle(N+8);

    // reset mid-stream
    for (int i = 0; i < 10; i++)
      step(0, 1, 1, IW'(i), IW'(i), rnd_row(), rnd_row());
    do_reset();
    idle(N+4);
    step(0, 1, 1, 5'd2, 5'd2, rnd_row(), rnd_row());
    idle(N+4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
